// File: rtl/neuron_core_pkg.sv
// Shared constants and types for the neuron core spike path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuron_core_pkg;

  localparam int NUM_NEURONS = 256;
  localparam int IDX_W       = $clog2(NUM_NEURONS);
  localparam int CNT_W       = $clog2(NUM_NEURONS) + 1;

  // Wishbone base address of the spike-out SRAM the packer feeds.
  localparam logic [31:0] SPIKE_SINK_BASE = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } pk_state_e;

endpackage

// File: rtl/neuron_spike_packer.sv
// Packs serial per-neuron spike beats into one frame vector for the spike SRAM.
// Latency: last in-order beat at edge N -> write enable from N until the first idle-bus edge, done pulse after.
// Backpressure: ready only while collecting; holds the write enable while the sink bus is busy.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   frame_start_i             one-cycle pulse opening a timestep frame
//   neuron_valid_i/_ready_o   beat handshake; neuron_idx_i, neuron_spike_i carry the beat
//   bus_busy_i                sink Wishbone cycle active (external writes ignored)
//   spike_data_o/_count_o     last completed frame and its popcount
//   spike_write_en_o          external write enable into the sink
//   frame_done_o              one-cycle pulse after the frame is handed over
//   busy_o, seq_err_o/err_clr_i  activity flag, sticky sequencing error and its clear
module neuron_spike_packer
  import neuron_core_pkg::*;
(
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   frame_start_i,
  input  logic                   neuron_valid_i,
  input  logic [IDX_W-1:0]       neuron_idx_i,
  input  logic                   neuron_spike_i,
  output logic                   neuron_ready_o,
  input  logic                   bus_busy_i,
  output logic [NUM_NEURONS-1:0] spike_data_o,
  output logic                   spike_write_en_o,
  output logic [CNT_W-1:0]       spike_count_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   seq_err_o,
  input  logic                   err_clr_i
);

  pk_state_e              state_q, state_d;
  logic                   ready_q;
  logic                   done_q;
  logic                   err_q;
  logic                   pend_q;
  logic [NUM_NEURONS-1:0] shadow_q;
  logic [NUM_NEURONS-1:0] data_q;
  logic [IDX_W:0]         exp_idx_q;
  logic [CNT_W-1:0]       run_cnt_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   clear_frame;
  logic                   accept;
  logic                   in_order;
  logic                   abort;
  logic                   beat_ok;
  logic                   beat_bad;
  logic                   last_beat;
  logic                   push_exit;
  logic [NUM_NEURONS-1:0] shadow_nxt;
  logic [CNT_W-1:0]       run_cnt_nxt;

  // A frame_start seen while collecting wins over any beat in the same cycle.
  assign abort     = (state_q == COLLECT) && frame_start_i;
  assign accept    = (state_q == COLLECT) && neuron_valid_i && ready_q;
  // exp_idx carries an extra MSB so it can sit at NUM_NEURONS without matching index 0.
  assign in_order  = ({1'b0, neuron_idx_i} == exp_idx_q);
  assign beat_ok   = accept && !abort && in_order;
  assign beat_bad  = accept && !abort && !in_order;
  assign last_beat = beat_ok && (neuron_idx_i == IDX_W'(NUM_NEURONS - 1));
  assign push_exit = (state_q == PUSH) && !bus_busy_i;

  assign run_cnt_nxt = run_cnt_q + {{(CNT_W-1){1'b0}}, neuron_spike_i};

  always_comb begin
    shadow_nxt               = shadow_q;
    shadow_nxt[neuron_idx_i] = neuron_spike_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clear_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d     = COLLECT;
          clear_frame = 1'b1;
        end
      end
      COLLECT: begin
        if (abort) begin
          clear_frame = 1'b1;
        end else if (last_beat) begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (!bus_busy_i) begin
          // A start arriving on the exit edge itself is honoured like a pending one.
          if (pend_q || frame_start_i) begin
            state_d     = COLLECT;
            clear_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      shadow_q  <= '0;
      data_q    <= '0;
      exp_idx_q <= '0;
      run_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      ready_q <= (state_d == COLLECT);
      done_q  <= push_exit;

      if (clear_frame) begin
        shadow_q  <= '0;
        exp_idx_q <= '0;
        run_cnt_q <= '0;
      end else if (beat_ok) begin
        shadow_q  <= shadow_nxt;
        exp_idx_q <= exp_idx_q + {{IDX_W{1'b0}}, 1'b1};
        run_cnt_q <= run_cnt_nxt;
      end

      // Published outputs move only when a frame completes.
      if (last_beat) begin
        data_q <= shadow_nxt;
        cnt_q  <= run_cnt_nxt;
      end

      if (push_exit)                               pend_q <= 1'b0;
      else if ((state_q == PUSH) && frame_start_i) pend_q <= 1'b1;

      if (abort || beat_bad) err_q <= 1'b1;
      else if (err_clr_i)    err_q <= 1'b0;
    end
  end

  // The sink may ignore writes while its bus is busy, so the enable simply
  // stays up for the whole PUSH; repeated captures of the same frame are benign.
  assign spike_write_en_o = (state_q == PUSH);
  assign neuron_ready_o   = ready_q;
  assign spike_data_o     = data_q;
  assign spike_count_o    = cnt_q;
  assign frame_done_o     = done_q;
  assign busy_o           = (state_q != IDLE);
  assign seq_err_o        = err_q;

endmodule

// File: tb/tb_neuron_spike_packer.sv
// Bench for neuron_spike_packer: table of whole frames plus hand-built corner sequences.
// Latency: n/a.
// Backpressure: drives bus_busy_i to stretch the push phase.
module tb_neuron_spike_packer;
  import neuron_core_pkg::*;

  logic                   clk = 1'b0;
  logic                   wb_rst_i;
  logic                   frame_start_i;
  logic                   neuron_valid_i;
  logic [IDX_W-1:0]       neuron_idx_i;
  logic                   neuron_spike_i;
  logic                   neuron_ready_o;
  logic                   bus_busy_i;
  logic [NUM_NEURONS-1:0] spike_data_o;
  logic                   spike_write_en_o;
  logic [CNT_W-1:0]       spike_count_o;
  logic                   frame_done_o;
  logic                   busy_o;
  logic                   seq_err_o;
  logic                   err_clr_i;

  neuron_spike_packer dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (wb_rst_i),
    .frame_start_i   (frame_start_i),
    .neuron_valid_i  (neuron_valid_i),
    .neuron_idx_i    (neuron_idx_i),
    .neuron_spike_i  (neuron_spike_i),
    .neuron_ready_o  (neuron_ready_o),
    .bus_busy_i      (bus_busy_i),
    .spike_data_o    (spike_data_o),
    .spike_write_en_o(spike_write_en_o),
    .spike_count_o   (spike_count_o),
    .frame_done_o    (frame_done_o),
    .busy_o          (busy_o),
    .seq_err_o       (seq_err_o),
    .err_clr_i       (err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_NEURONS-1:0] spikes;
    int                     busy;
    int                     exp_cnt;
    int                     exp_we;
  } vec_t;

  typedef struct {
    logic [NUM_NEURONS-1:0] data;
    int                     cnt;
    int                     we;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   we_cnt   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NUM_NEURONS-1:0] act,
                       input logic [NUM_NEURONS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [NUM_NEURONS-1:0] d, input int c, input int w);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    e.we   = w;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic send_range(input logic [NUM_NEURONS-1:0] pat, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int n;
      neuron_valid_i = 1'b1;
      neuron_idx_i   = i[IDX_W-1:0];
      neuron_spike_i = pat[i];
      n = 0;
      while (!neuron_ready_o && n < 20) begin
        tick();
        n++;
      end
      if (!neuron_ready_o) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: idx %0d ready=%b required 1", i, neuron_ready_o);
      end
      tick();
    end
    neuron_valid_i = 1'b0;
  endtask

  // Scoreboard side: every write-enable cycle must carry the pending frame,
  // and each done pulse retires one expected frame.
  always @(negedge clk) begin
    if (spike_write_en_o) begin
      we_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: write_en=1 required 0");
      end else begin
        check("push_data_stable", spike_data_o, sb[0].data);
      end
    end
    if (frame_done_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: frame_done=1 required 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_data", spike_data_o, e.data);
        check("frame_count", NUM_NEURONS'(spike_count_o), NUM_NEURONS'(e.cnt));
        check("write_en_cycles", NUM_NEURONS'(we_cnt), NUM_NEURONS'(e.we));
      end
      we_cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_NEURONS-1:0] pat_b, pat_d1, pat_d2, ones, prev_data;
    int                     prev_cnt;

    vecs[0].spikes = '0;
    vecs[0].spikes[0] = 1'b1;
    vecs[0].spikes[37] = 1'b1;
    vecs[0].spikes[255] = 1'b1;
    vecs[0].busy = 0; vecs[0].exp_cnt = 3; vecs[0].exp_we = 1;
    vecs[1].spikes = vecs[0].spikes;
    vecs[1].busy = 5; vecs[1].exp_cnt = 3; vecs[1].exp_we = 6;
    vecs[2].spikes = '1;
    vecs[2].busy = 0; vecs[2].exp_cnt = 256; vecs[2].exp_we = 1;
    vecs[3].spikes = {128{2'b01}};
    vecs[3].busy = 2; vecs[3].exp_cnt = 128; vecs[3].exp_we = 3;
    vecs[4].spikes = '0;
    vecs[4].busy = 0; vecs[4].exp_cnt = 0; vecs[4].exp_we = 1;

    wb_rst_i = 1'b1; frame_start_i = 1'b0; neuron_valid_i = 1'b0;
    neuron_idx_i = '0; neuron_spike_i = 1'b0; bus_busy_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();

    check("rst_data", spike_data_o, '0);
    check("rst_count", NUM_NEURONS'(spike_count_o), '0);
    check("rst_we", NUM_NEURONS'(spike_write_en_o), '0);
    check("rst_ready", NUM_NEURONS'(neuron_ready_o), '0);
    check("rst_done", NUM_NEURONS'(frame_done_o), '0);
    check("rst_busy", NUM_NEURONS'(busy_o), '0);
    check("rst_err", NUM_NEURONS'(seq_err_o), '0);

    // Table of complete in-order frames with varying sink-busy stretch.
    for (int k = 0; k < 5; k++) begin
      push_exp(vecs[k].spikes, vecs[k].exp_cnt, vecs[k].exp_we);
      pulse_start();
      check("ready_after_start", NUM_NEURONS'(neuron_ready_o), NUM_NEURONS'(1));
      send_range(vecs[k].spikes, 0, NUM_NEURONS - 1);
      check("ready_low_in_push", NUM_NEURONS'(neuron_ready_o), '0);
      if (vecs[k].busy > 0) begin
        bus_busy_i = 1'b1;
        repeat (vecs[k].busy) tick();
        bus_busy_i = 1'b0;
      end
      repeat (3) tick();
      check("tbl_err", NUM_NEURONS'(seq_err_o), '0);
      check("tbl_idle", NUM_NEURONS'(busy_o), '0);
    end

    // Out-of-order beat dropped; error set wins over a same-cycle clear.
    pat_b = '0;
    pat_b[3] = 1'b1; pat_b[9] = 1'b1; pat_b[200] = 1'b1;
    push_exp(pat_b, 3, 1);
    pulse_start();
    send_range(pat_b, 0, 8);
    neuron_valid_i = 1'b1; neuron_idx_i = 8'd10; neuron_spike_i = 1'b1; err_clr_i = 1'b1;
    tick();
    neuron_valid_i = 1'b0; err_clr_i = 1'b0;
    check("ooo_err_set", NUM_NEURONS'(seq_err_o), NUM_NEURONS'(1));
    send_range(pat_b, 9, NUM_NEURONS - 1);
    repeat (3) tick();
    check("ooo_err_sticky", NUM_NEURONS'(seq_err_o), NUM_NEURONS'(1));
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    check("ooo_err_clr", NUM_NEURONS'(seq_err_o), '0);

    // Abort after 100 beats; a beat in the abort cycle must be dropped.
    prev_data = pat_b; prev_cnt = 3;
    ones = '1;
    pulse_start();
    send_range(ones, 0, 99);
    neuron_valid_i = 1'b1; neuron_idx_i = 8'd100; neuron_spike_i = 1'b1; frame_start_i = 1'b1;
    tick();
    neuron_valid_i = 1'b0; frame_start_i = 1'b0;
    check("abort_err", NUM_NEURONS'(seq_err_o), NUM_NEURONS'(1));
    check("abort_data_hold", spike_data_o, prev_data);
    check("abort_cnt_hold", NUM_NEURONS'(spike_count_o), NUM_NEURONS'(prev_cnt));
    check("abort_still_collect", NUM_NEURONS'(neuron_ready_o), NUM_NEURONS'(1));
    push_exp(ones, 256, 1);
    send_range(ones, 0, NUM_NEURONS - 1);
    repeat (3) tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    check("abort_err_clr", NUM_NEURONS'(seq_err_o), '0);

    // frame_start during PUSH queues the next frame without an error.
    pat_d1 = {64{4'b1000}};
    pat_d2 = {32{8'h81}};
    push_exp(pat_d1, 64, 4);
    pulse_start();
    send_range(pat_d1, 0, NUM_NEURONS - 1);
    bus_busy_i = 1'b1;
    tick();
    frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
    tick();
    bus_busy_i = 1'b0;
    tick();
    check("pend_ready", NUM_NEURONS'(neuron_ready_o), NUM_NEURONS'(1));
    check("pend_busy", NUM_NEURONS'(busy_o), NUM_NEURONS'(1));
    check("pend_no_err", NUM_NEURONS'(seq_err_o), '0);
    push_exp(pat_d2, 64, 1);
    send_range(pat_d2, 0, NUM_NEURONS - 1);
    repeat (3) tick();
    check("pend_idle", NUM_NEURONS'(busy_o), '0);

    // Reset at beat 128 discards everything; beats ignored until a new start.
    pulse_start();
    send_range(ones, 0, 127);
    neuron_valid_i = 1'b1; neuron_idx_i = 8'd128; neuron_spike_i = 1'b1; wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("mrst_data", spike_data_o, '0);
    check("mrst_count", NUM_NEURONS'(spike_count_o), '0);
    check("mrst_we", NUM_NEURONS'(spike_write_en_o), '0);
    check("mrst_ready", NUM_NEURONS'(neuron_ready_o), '0);
    check("mrst_busy", NUM_NEURONS'(busy_o), '0);
    neuron_idx_i = 8'd0;
    repeat (3) begin
      tick();
      check("mrst_ignore_ready", NUM_NEURONS'(neuron_ready_o), '0);
      check("mrst_ignore_err", NUM_NEURONS'(seq_err_o), '0);
    end
    neuron_valid_i = 1'b0;
    push_exp(vecs[0].spikes, 3, 1);
    pulse_start();
    send_range(vecs[0].spikes, 0, NUM_NEURONS - 1);
    repeat (4) tick();

    check("sb_drained", NUM_NEURONS'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
